// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, the receiver/transmitter state
// encoding, and a 2-of-3 vote helper.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    // The transmitter reuses this encoding, so keep the literal values fixed.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage synchronizer for a single asynchronous input. Flops reset to
// RST_VAL so an idle-high line does not produce a spurious edge after reset.
module sync_2ff #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] ff;

    // Shift the asynchronous input through DEPTH flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= {DEPTH{RST_VAL}};
        end else begin
            ff <= {ff[DEPTH-2:0], d};
        end
    end

    assign q = ff[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, OVERSAMPLE b_tick pulses per bit.
// Optional build macro: UART_RX_MAJORITY_EN -- each mid-bit decision becomes
// a 2-of-3 vote over ticks centre-1, centre, centre+1, taken at centre+1.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | timing to mid start bit, rejecting glitches as false starts
// DATA  | sampling 8 data bits at mid-bit, shifting in from the MSB side
// STOP  | sampling the stop bit; high -> rx_done, low -> frame_err
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      b_tick,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_done,
    output logic                      rx_busy,
    output logic                      frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(UART_DATA_BITS);

    localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);
    localparam logic [TW-1:0] BIT_DEC  = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    // The vote needs centre+1, so the start decision slips one tick; every
    // later decision inherits that shift through the 16-tick bit period.
    localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2);
`else
    localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2 - 1);
`endif

    rx_state_t                 state, state_n;
    logic [TW-1:0]             tick_cnt, tick_n;
    logic [BW-1:0]             bit_cnt, bit_n;
    logic [UART_DATA_BITS-1:0] shift_reg, shift_n;
    logic [UART_DATA_BITS-1:0] data_n;
    logic                      done_n, ferr_n;
    logic                      rx_s, rx_prev;
    logic                      sample;
    logic                      fall;

    sync_2ff #(
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Delayed copy of the synchronized line for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_s;
        end
    end

    // A held-low line keeps rx_prev low, so a break cannot retrigger IDLE.
    assign fall = rx_prev & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Keep the two previous tick samples; at a decision tick they are the
    // centre-1 and centre samples, and rx_s is centre+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= 2'b11;
        end else if (b_tick) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign sample = maj3(hist[1], hist[0], rx_s);
`else
    assign sample = rx_s;
`endif

    // State, counters, shift register and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
            rx_data   <= data_n;
            rx_done   <= done_n;
            frame_err <= ferr_n;
        end
    end

    // Next-state and datapath decode. The start edge is watched on every
    // clock because it lasts only one cycle; all timing advances on b_tick.
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        data_n  = rx_data;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end
            START: begin
                if (b_tick) begin
                    if (tick_cnt == START_DEC) begin
                        tick_n = '0;
                        if (!sample) begin
                            state_n = DATA;
                            bit_n   = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (b_tick) begin
                    if (tick_cnt == BIT_DEC) begin
                        shift_n = {sample, shift_reg[UART_DATA_BITS-1:1]};
                        tick_n  = '0;
                        bit_n   = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state_n = STOP;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (b_tick) begin
                    if (tick_cnt == BIT_DEC) begin
                        tick_n  = '0;
                        state_n = IDLE;
                        if (sample) begin
                            data_n = shift_reg;
                            done_n = 1'b1;
                        end else begin
                            ferr_n = 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: 16 ticks per bit, one tick every 4 clocks,
// so one bit period is 64 clocks. Frames are aligned to the tick phase so
// strobe latency and the glitch position are deterministic.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       b_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    int tests_run    = 0;
    int tests_failed = 0;

    int cyc       = 0;
    int done_cnt  = 0;
    int ferr_cnt  = 0;
    int busy_cnt  = 0;
    int done_cyc  = 0;
    int frame_cyc = 0;
    logic [7:0] got_q[$];

    logic [1:0] tick_div = 2'd0;

`ifdef UART_RX_MAJORITY_EN
    localparam int         EXP_LAT    = 612;
    localparam logic [7:0] EXP_GLITCH = 8'h01;
`else
    localparam int         EXP_LAT    = 608;
    localparam logic [7:0] EXP_GLITCH = 8'h00;
`endif

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .b_tick    (b_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Oversample tick: high for one clock out of every four.
    initial begin
        b_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_div = tick_div + 2'd1;
            b_tick   = (tick_div == 2'd0);
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            got_q.push_back(rx_data);
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (rx_busy)   busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input bit align, input bit glitch);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        if (align) begin
            do @(posedge clk); while (b_tick !== 1'b1);
            @(negedge clk);
        end
        frame_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (glitch && i == 1) begin
                repeat (28) @(negedge clk);
                rx = 1'b0;
                repeat (4) @(negedge clk);
                rx = bits[1];
                repeat (32) @(negedge clk);
            end else begin
                repeat (64) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++;
        if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected %h", rx_data, 8'h00); end
        tests_run++;
        if (rx_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", rx_done); end
        tests_run++;
        if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        tests_run++;
        if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        rst = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b expected 0", rx_busy); end
    endtask

    task automatic test_single_byte();
        int d0, f0, q0;
        logic [7:0] got;
        d0 = done_cnt; f0 = ferr_cnt; q0 = got_q.size();
        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        repeat (64) @(negedge clk);
        got = (got_q.size() > q0) ? got_q[q0] : 8'hxx;
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0); end
        tests_run++;
        if (got !== 8'h55) begin tests_failed++; $display("FAIL single_strobe_data: got %h expected %h", got, 8'h55); end
        tests_run++;
        if (rx_data !== 8'h55) begin tests_failed++; $display("FAIL single_held_data: got %h expected %h", rx_data, 8'h55); end
        tests_run++;
        if (ferr_cnt - f0 !== 0) begin tests_failed++; $display("FAIL single_ferr: got %0d expected 0", ferr_cnt - f0); end
        tests_run++;
        if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after: got %b expected 0", rx_busy); end
        tests_run++;
        if (done_cyc - frame_cyc !== EXP_LAT) begin tests_failed++; $display("FAIL single_latency: got %0d expected %0d", done_cyc - frame_cyc, EXP_LAT); end
    endtask

    task automatic test_back_to_back();
        int d0, f0, q0;
        logic [7:0] g0, g1;
        d0 = done_cnt; f0 = ferr_cnt; q0 = got_q.size();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        send_frame(8'hA7, 1'b1, 1'b0, 1'b0);
        repeat (64) @(negedge clk);
        g0 = (got_q.size() > q0)     ? got_q[q0]     : 8'hxx;
        g1 = (got_q.size() > q0 + 1) ? got_q[q0 + 1] : 8'hxx;
        tests_run++;
        if (done_cnt - d0 !== 2) begin tests_failed++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
        tests_run++;
        if (g0 !== 8'h3C) begin tests_failed++; $display("FAIL b2b_first: got %h expected %h", g0, 8'h3C); end
        tests_run++;
        if (g1 !== 8'hA7) begin tests_failed++; $display("FAIL b2b_second: got %h expected %h", g1, 8'hA7); end
        tests_run++;
        if (ferr_cnt - f0 !== 0) begin tests_failed++; $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_false_start();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        do @(posedge clk); while (b_tick !== 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        tests_run++;
        if (rx_busy !== 1'b1) begin tests_failed++; $display("FAIL false_busy_high: got %b expected 1", rx_busy); end
        rx = 1'b1;
        repeat (24) @(negedge clk);
        tests_run++;
        if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL false_busy_drop: got %b expected 0", rx_busy); end
        repeat (128) @(negedge clk);
        tests_run++;
        if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL false_done: got %0d expected 0", done_cnt - d0); end
        tests_run++;
        if (ferr_cnt - f0 !== 0) begin tests_failed++; $display("FAIL false_ferr: got %0d expected 0", ferr_cnt - f0); end
        tests_run++;
        if (rx_data !== 8'hA7) begin tests_failed++; $display("FAIL false_data: got %h expected %h", rx_data, 8'hA7); end
    endtask

    task automatic test_frame_error();
        int d0, f0, b0;
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        b0 = busy_cnt;
        repeat (192) @(negedge clk);
        tests_run++;
        if (ferr_cnt - f0 !== 1) begin tests_failed++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt - f0); end
        tests_run++;
        if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL ferr_done: got %0d expected 0", done_cnt - d0); end
        tests_run++;
        if (rx_data !== 8'hA7) begin tests_failed++; $display("FAIL ferr_data_kept: got %h expected %h", rx_data, 8'hA7); end
        tests_run++;
        if (busy_cnt - b0 !== 0) begin tests_failed++; $display("FAIL ferr_break_retrigger: busy cycles %0d expected 0", busy_cnt - b0); end
        rx = 1'b1;
        repeat (64) @(negedge clk);
        tests_run++;
        if (ferr_cnt - f0 !== 1) begin tests_failed++; $display("FAIL ferr_after_break: got %0d expected 1", ferr_cnt - f0); end
    endtask

    task automatic test_reset_mid_frame();
        int d0, f0, q0;
        logic [7:0] got;
        d0 = done_cnt; f0 = ferr_cnt;
        fork
            send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
            begin
                @(negedge rx);
                repeat (288) @(negedge clk);
                tests_run++;
                if (rx_busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_before: got %b expected 1", rx_busy); end
                rst = 1'b0;
                #1;
                tests_run++;
                if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL mid_rst_data: got %h expected %h", rx_data, 8'h00); end
                tests_run++;
                if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_busy: got %b expected 0", rx_busy); end
                tests_run++;
                if (rx_done !== 1'b0 || frame_err !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_strobes: done %b ferr %b expected 0 0", rx_done, frame_err); end
                repeat (3) @(negedge clk);
                rst = 1'b1;
            end
        join
        repeat (64) @(negedge clk);
        tests_run++;
        if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin tests_failed++; $display("FAIL mid_no_strobe: done %0d ferr %0d expected 0 0", done_cnt - d0, ferr_cnt - f0); end
        d0 = done_cnt; q0 = got_q.size();
        send_frame(8'h81, 1'b1, 1'b1, 1'b0);
        repeat (64) @(negedge clk);
        got = (got_q.size() > q0) ? got_q[q0] : 8'hxx;
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL post_rst_done: got %0d expected 1", done_cnt - d0); end
        tests_run++;
        if (got !== 8'h81) begin tests_failed++; $display("FAIL post_rst_data: got %h expected %h", got, 8'h81); end
    endtask

    task automatic test_glitch();
        int d0;
        d0 = done_cnt;
        send_frame(8'h01, 1'b1, 1'b1, 1'b1);
        repeat (64) @(negedge clk);
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL glitch_done: got %0d expected 1", done_cnt - d0); end
        tests_run++;
        if (rx_data !== EXP_GLITCH) begin tests_failed++; $display("FAIL glitch_data: got %h expected %h", rx_data, EXP_GLITCH); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_reset_mid_frame();
        test_glitch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
